// File: rtl/led_matrix_scan.sv
// Row-multiplexed 8x8 LED matrix driver: one frame snapshot per scan, dead time between rows.
// Optional LED_SCAN_DIM_EN adds a brightness input and 3-bit PWM gating of the column data.
module led_matrix_scan #(
  parameter int ROW_CYCLES     = 1000,
  parameter int BLANK_CYCLES   = 16,
  parameter bit ROW_ACTIVE_LOW = 1'b0,
  parameter bit COL_ACTIVE_LOW = 1'b0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [63:0] matrix,
`ifdef LED_SCAN_DIM_EN
  input  logic [2:0]  brightness,
`endif
  output logic [7:0]  row_sel,
  output logic [7:0]  col_data,
  output logic [2:0]  row_idx,
  output logic        frame_start
);

  localparam int CW = (ROW_CYCLES > 1) ? $clog2(ROW_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(ROW_CYCLES - 1);
  localparam logic [CW-1:0] BLANK_C = CW'(BLANK_CYCLES);
  localparam logic [7:0]    ROW_INV = ROW_ACTIVE_LOW ? 8'hFF : 8'h00;
  localparam logic [7:0]    COL_INV = COL_ACTIVE_LOW ? 8'hFF : 8'h00;

  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    row_q, row_d;
  logic [63:0]   shadow_q, shadow_d;
  logic [7:0]    row_sel_q, row_sel_d;
  logic [7:0]    col_data_q, col_data_d;
  logic [2:0]    row_idx_q, row_idx_d;
  logic          frame_start_q, frame_start_d;
  logic          snap;
  logic          drive;
  logic [7:0]    row_on;
  logic [7:0]    col_on;
`ifdef LED_SCAN_DIM_EN
  logic [2:0]    pwm_q, pwm_d;
`endif

  always_comb begin
    snap     = (row_q == 3'd0) && (cnt_q == '0);
    drive    = (cnt_q >= BLANK_C);
    cnt_d    = (cnt_q == CNT_MAX) ? '0 : cnt_q + 1'b1;
    row_d    = (cnt_q == CNT_MAX) ? row_q + 3'd1 : row_q;
    shadow_d = snap ? matrix : shadow_q;
    row_on   = drive ? (8'h01 << row_q) : 8'h00;
    col_on   = drive ? shadow_q[{row_q, 3'b000} +: 8] : 8'h00;
`ifdef LED_SCAN_DIM_EN
    pwm_d    = pwm_q + 3'd1;
    if (pwm_q > brightness) col_on = 8'h00;
`endif
    // Polarity is applied after blanking so inactive always means all-ones when active-low.
    row_sel_d     = row_on ^ ROW_INV;
    col_data_d    = col_on ^ COL_INV;
    row_idx_d     = row_q;
    frame_start_d = snap;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q         <= '0;
      row_q         <= 3'd0;
      shadow_q      <= 64'd0;
      row_sel_q     <= ROW_INV;
      col_data_q    <= COL_INV;
      row_idx_q     <= 3'd0;
      frame_start_q <= 1'b0;
    end else begin
      cnt_q         <= cnt_d;
      row_q         <= row_d;
      shadow_q      <= shadow_d;
      row_sel_q     <= row_sel_d;
      col_data_q    <= col_data_d;
      row_idx_q     <= row_idx_d;
      frame_start_q <= frame_start_d;
    end
  end

`ifdef LED_SCAN_DIM_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) pwm_q <= 3'd0;
    else        pwm_q <= pwm_d;
  end
`endif

  assign row_sel     = row_sel_q;
  assign col_data    = col_data_q;
  assign row_idx     = row_idx_q;
  assign frame_start = frame_start_q;

endmodule
